core_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port on-chip RAM (32-bit data, 13-bit word

---
 rtl/core_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_core_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
// Round-robin arbiter that shares one single-port on-chip RAM (1-cycle read
// latency) among N_REQ core-side Avalon-MM masters. One access is accepted per
// cycle. A requester is stalled through waitrequest only when another requester
// holds the grant. A requester that keeps its request active may hold the RAM
// for up to MAX_HOLD consecutive grants. After that, the grant rotates.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   req_address          flat, slice i = [i*ADDR_W +: ADDR_W]
//   req_byteenable       flat, slice i = [i*4 +: 4]
//   req_read/req_write   per-requester read / write strobes
//   req_writedata        flat, slice i = [i*32 +: 32]
//   req_waitrequest      1 = request of requester i not accepted this cycle
//   req_readdata         mem_readdata broadcast to every slice
//   req_readdatavalid    bit i = read data for requester i valid this cycle
//   mem_*                RAM s1 slave side (address, byteenable, chipselect,
//                        write, writedata, readdata)
// -----------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int N_REQ    = 5,
    parameter int ADDR_W   = 13,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ*ADDR_W-1:0] req_address,
    input  logic [N_REQ*4-1:0]      req_byteenable,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*32-1:0]     req_writedata,
    output logic [N_REQ-1:0]        req_waitrequest,
    output logic [N_REQ*32-1:0]     req_readdata,
    output logic [N_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [3:0]              mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [31:0]             mem_writedata,
    input  logic [31:0]             mem_readdata
);

    localparam int             IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]     MAX_HOLD_L = 4'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    // Registered arbitration state
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_last;
    logic [3:0]       r_hold_cnt;
    logic             r_rd_pend;
    logic [IDX_W-1:0] r_rd_own;

    // Combinational grant
    logic [N_REQ-1:0] w_act;
    logic [N_REQ-1:0] w_gnt;
    logic             w_gnt_valid;
    logic [IDX_W-1:0] w_g;

    assign w_act = req_read | req_write;

    // The last winner keeps the RAM while it is still active and under its
    // hold budget. Otherwise the search starts at r_ptr. The search runs from
    // the farthest offset down to offset 0, so the nearest active index at or
    // after r_ptr is the last one written.
    always_comb begin
        int idx;
        w_gnt_valid = 1'b0;
        w_g         = '0;
        idx         = 0;
        if (!reset) begin
            if ((r_hold_cnt < MAX_HOLD_L) && w_act[r_last]) begin
                w_gnt_valid = 1'b1;
                w_g         = r_last;
            end else begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= N_REQ) idx = idx - N_REQ;
                    if (w_act[idx[IDX_W-1:0]]) begin
                        w_gnt_valid = 1'b1;
                        w_g         = idx[IDX_W-1:0];
                    end
                end
            end
        end
    end

    // Per-requester handshake outputs
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_gnt[gi]                   = w_gnt_valid && (w_g == IDX_W'(gi));
            assign req_waitrequest[gi]         = ~w_gnt[gi];
            assign req_readdata[gi*32 +: 32]   = mem_readdata;
            assign req_readdatavalid[gi]       = r_rd_pend && (r_rd_own == IDX_W'(gi));
        end
    endgenerate

    // Memory-side mux. All fields are zero when no grant is issued.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (w_gnt_valid) begin
            mem_address    = req_address[int'(w_g)*ADDR_W +: ADDR_W];
            mem_byteenable = req_byteenable[int'(w_g)*4 +: 4];
            mem_writedata  = req_writedata[int'(w_g)*32 +: 32];
            mem_chipselect = 1'b1;
            mem_write      = req_write[w_g];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_last     <= '0;
            r_hold_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_own   <= '0;
        end else if (w_gnt_valid) begin
            // A request with both strobes set is handled as a write, so it
            // returns no read data.
            r_rd_pend <= req_read[w_g] & ~req_write[w_g];
            r_rd_own  <= w_g;
            if (w_g == r_last) begin
                if (r_hold_cnt != 4'hF) r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
                r_last     <= w_g;
                r_hold_cnt <= 4'd1;
            end
            r_ptr <= (w_g == LAST_IDX) ? '0 : w_g + IDX_W'(1);
        end else begin
            r_rd_pend  <= 1'b0;
            r_hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arbiter
// Directed bench for core_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_core_mem_arbiter;

    localparam int N  = 5;
    localparam int AW = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*AW-1:0]   req_address;
    logic [N*4-1:0]    req_byteenable;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*32-1:0]   req_writedata;
    logic [N-1:0]      req_waitrequest;
    logic [N*32-1:0]   req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic [AW-1:0]     mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .MAX_HOLD(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_address       (req_address),
        .req_byteenable    (req_byteenable),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata)
    );

    // Behavioural single-port RAM: byte-masked writes, read data one cycle later.
    logic [31:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic clear_all();
        req_address    = '0;
        req_byteenable = '0;
        req_read       = '0;
        req_write      = '0;
        req_writedata  = '0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
        req_read[i]              = rd;
        req_write[i]             = wr;
        req_address[i*AW +: AW]  = a;
        req_byteenable[i*4 +: 4] = be;
        req_writedata[i*32 +: 32] = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_all();
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (req_waitrequest !== 5'b11111 || mem_chipselect !== 1'b0 || req_readdatavalid !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs: wait=%b cs=%b valid=%b required wait=11111 cs=0 valid=00000",
                     req_waitrequest, mem_chipselect, req_readdatavalid);
        end
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (req_waitrequest !== 5'b11111 || mem_chipselect !== 1'b0 || mem_address !== '0) begin
            failures++;
            $display("FAIL idle_outputs: wait=%b cs=%b addr=%h required 11111/0/0000",
                     req_waitrequest, mem_chipselect, mem_address);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        clear_all();
        set_req(2, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF); #1;
        checks++;
        if (req_waitrequest !== 5'b11011 || mem_write !== 1'b1 || mem_address !== 13'h0010) begin
            failures++;
            $display("FAIL sr_write: wait=%b we=%b addr=%h required 11011/1/0010",
                     req_waitrequest, mem_write, mem_address);
        end
        @(negedge clk);
        clear_all();
        set_req(2, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0); #1;
        checks++;
        if (req_waitrequest !== 5'b11011 || mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL sr_grant: wait=%b cs=%b we=%b required 11011/1/0",
                     req_waitrequest, mem_chipselect, mem_write);
        end
        @(negedge clk);
        clear_all(); #1;
        checks++;
        if (req_readdatavalid !== 5'b00100 || req_readdata[2*32 +: 32] !== 32'hDEADBEEF
            || req_readdata[0 +: 32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sr_data: valid=%b data=%h required 00100/deadbeef",
                     req_readdatavalid, req_readdata[2*32 +: 32]);
        end
        $display("test_single_read: req2 addr 0010 -> %h", req_readdata[2*32 +: 32]);
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        clear_all();
        set_req(0, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hAAAAAAAA);
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 13'h1FFF, 4'b0100, 32'h11223344); #1;
        checks++;
        if (req_waitrequest !== 5'b11110 || mem_byteenable !== 4'b0100 || mem_writedata !== 32'h11223344) begin
            failures++;
            $display("FAIL bw_write: wait=%b be=%b wd=%h required 11110/0100/11223344",
                     req_waitrequest, mem_byteenable, mem_writedata);
        end
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        @(negedge clk);
        clear_all(); #1;
        checks++;
        if (req_readdatavalid !== 5'b00001 || req_readdata[0 +: 32] !== 32'hAA22AAAA) begin
            failures++;
            $display("FAIL bw_data: valid=%b data=%h required 00001/aa22aaaa",
                     req_readdatavalid, req_readdata[0 +: 32]);
        end
        $display("test_byte_write: req0 addr 1fff -> %h", req_readdata[0 +: 32]);
    endtask

    // All requesters read continuously from reset; grants go 0,0,0,0,1,1,1,1,...
    task automatic test_round_robin();
        int waits [N];
        int max_wait;
        int exp_g;
        int prev_g;
        logic [N-1:0] exp_wait;
        @(negedge clk);
        reset = 1'b1;
        clear_all();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
            waits[i] = 0;
        end
        max_wait = 0;
        prev_g   = -1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_g    = (c / 4) % N;
            exp_wait = ~(5'b00001 << exp_g);
            checks++;
            if (req_waitrequest !== exp_wait) begin
                failures++;
                $display("FAIL rr_grant c=%0d: wait=%b required %b", c, req_waitrequest, exp_wait);
            end
            if (prev_g >= 0) begin
                checks++;
                if (req_readdatavalid !== (5'b00001 << prev_g)) begin
                    failures++;
                    $display("FAIL rr_valid c=%0d: valid=%b required %b", c, req_readdatavalid,
                             5'b00001 << prev_g);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_waitrequest[i]) waits[i]++;
                else waits[i] = 0;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
            $display("rr cycle %0d: granted=%b", c, ~req_waitrequest);
            prev_g = exp_g;
        end
        checks++;
        if (max_wait !== 16) begin
            failures++;
            $display("FAIL rr_max_wait: got=%0d required 16", max_wait);
        end
        @(negedge clk);
        clear_all();
    endtask

    // Req 1 exhausts its hold budget (ptr becomes 2), then 1 and 3 collide.
    task automatic test_conflict();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_all();
            set_req(1, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
            if (c == 0) begin
                #1;
                checks++;
                if (req_waitrequest !== 5'b11101) begin
                    failures++;
                    $display("FAIL cf_first: wait=%b required 11101", req_waitrequest);
                end
            end
        end
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0); #1;
        checks++;
        if (req_waitrequest !== 5'b10111) begin
            failures++;
            $display("FAIL cf_grant3: wait=%b required 10111", req_waitrequest);
        end
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0); #1;
        checks++;
        if (req_waitrequest !== 5'b11101 || req_readdatavalid !== 5'b01000) begin
            failures++;
            $display("FAIL cf_grant1: wait=%b valid=%b required 11101/01000",
                     req_waitrequest, req_readdatavalid);
        end
        $display("test_conflict: req3 then req1 granted");
        @(negedge clk);
        clear_all();
    endtask

    task automatic test_rw_both();
        @(negedge clk);
        set_req(4, 1'b1, 1'b1, 13'h0020, 4'hF, 32'h00000005); #1;
        checks++;
        if (req_waitrequest !== 5'b01111 || mem_write !== 1'b1 || mem_writedata !== 32'h5
            || mem_address !== 13'h0020) begin
            failures++;
            $display("FAIL rw_write: wait=%b we=%b wd=%h addr=%h required 01111/1/00000005/0020",
                     req_waitrequest, mem_write, mem_writedata, mem_address);
        end
        @(negedge clk);
        set_req(4, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0); #1;
        checks++;
        if (req_readdatavalid !== 5'b00000) begin
            failures++;
            $display("FAIL rw_novalid: valid=%b required 00000", req_readdatavalid);
        end
        @(negedge clk);
        clear_all(); #1;
        checks++;
        if (req_readdatavalid !== 5'b10000 || req_readdata[4*32 +: 32] !== 32'h5) begin
            failures++;
            $display("FAIL rw_readback: valid=%b data=%h required 10000/00000005",
                     req_readdatavalid, req_readdata[4*32 +: 32]);
        end
        $display("test_rw_both: req4 addr 0020 -> %h", req_readdata[4*32 +: 32]);
    endtask

    task automatic test_reset_pending();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        reset = 1'b1; #1;
        checks++;
        if (req_waitrequest !== 5'b11111 || mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL rp_in_reset: wait=%b cs=%b we=%b required 11111/0/0",
                     req_waitrequest, mem_chipselect, mem_write);
        end
        @(negedge clk); #1;
        checks++;
        if (req_readdatavalid !== 5'b00000 || req_waitrequest !== 5'b11111) begin
            failures++;
            $display("FAIL rp_after_reset: valid=%b wait=%b required 00000/11111",
                     req_readdatavalid, req_waitrequest);
        end
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (req_waitrequest !== 5'b11110) begin
            failures++;
            $display("FAIL rp_first_grant: wait=%b required 11110", req_waitrequest);
        end
        @(negedge clk);
        clear_all(); #1;
        checks++;
        if (req_readdatavalid !== 5'b00001) begin
            failures++;
            $display("FAIL rp_valid: valid=%b required 00001", req_readdatavalid);
        end
        $display("test_reset_pending: first grant after release = %b", 5'b00001);
    endtask

    initial begin
        reset = 1'b1;
        clear_all();
        test_reset();
        test_single_read();
        test_byte_write();
        test_round_robin();
        test_conflict();
        test_rw_both();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
